drbg_aes_seq: RTL and testbench
===============================

Name: drbg_aes_seq

Overview:
CTR-DRBG sequencer (128-bit key, 256-bit seedlen) that owns one AES-128 cipher engine (ld/done/key/text_in/text_out handshake) and the DRBG working state (Key, V, reseed counter). It accepts instantiate, reseed and generate commands from the TRNG control FSM. It issues the AES block operations for Update and Generate, and streams 128-bit random blocks to the output FIFO with backpressure.

Parameters:
CNT_W, 32, reseed counter width
RESEED_LIMIT, 32'h0001_0000, maximum generate commands allowed between reseeds

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when valid&ready
cmd_op  in  2  0=instantiate, 1=reseed, 2=generate, 3=reserved
cmd_seed  in  256  provided data for instantiate/reseed; ignored for generate
cmd_nblk  in  8  number of 128-bit blocks for generate (1..255)
err  out  1  one-cycle pulse when a command is rejected
busy  out  1  high whenever state != IDLE
reseed_req  out  1  level; high when rcnt > RESEED_LIMIT
out_valid  out  1  random block valid
out_ready  in  1  sink accepts block
out_data  out  128  random block
aes_ld  out  1  one-cycle start pulse to the AES engine
aes_key  out  128  current Key register, stable for the whole operation
aes_text_in  out  128  current V register
aes_done  in  1  one-cycle pulse; aes_text_out is valid in the same cycle
aes_text_out  in  128  cipher result

Behaviour:
- Reset values: K=0, V=0, rcnt=0, inst=0, tmp0=0, state=IDLE, all outputs 0 except cmd_ready=1. Reset mid-operation aborts immediately; any aes_done arriving after reset is ignored.
- Command acceptance in IDLE:
  - Reject (err pulse, stay in IDLE) on: op=3; op=1/2 with inst=0; op=2 with cmd_nblk=0; op=2 with rcnt>RESEED_LIMIT.
  - Otherwise latch seed and nblk, then go to the operation.
- Instantiate: load K=0, V=0, then run UPDATE(seed). Reseed: run UPDATE(seed). Both finish with rcnt=1, inst=1.
- UPDATE(pd) state sequence, each step is 1 cycle unless noted:
  - U_LD0: V<=V+1, then aes_ld the next cycle with the new V.
  - U_W0: wait for aes_done; tmp0<=aes_text_out.
  - U_LD1: V<=V+1, then aes_ld.
  - U_W1: wait for aes_done.
  - U_COMMIT: K<=tmp0^pd[255:128], V<=text_out^pd[127:0], then return to IDLE.
  - The increment is registered one cycle before aes_ld, so aes_text_in is never combinationally V+1.
- GENERATE states:
  - G_LD: V<=V+1, then aes_ld.
  - G_W: wait for aes_done; capture into out_data and set out_valid.
  - G_OUT: hold out_data/out_valid until out_ready. On handshake, decrement the block count: if nonzero go to G_LD, else run UPDATE(0) and then rcnt<=rcnt+1.
- V arithmetic is modulo 2^128; V=all-ones +1 wraps to 0. rcnt saturates at all-ones.
- Exactly one AES operation is outstanding at a time. aes_ld is asserted only in the cycle after a _LD state. aes_done outside the U_W0/U_W1/G_W states is ignored.
- out_valid is never asserted during UPDATE. out_data and out_valid are stable while out_valid&~out_ready.
- Minimum latency per AES block is engine latency + 2 cycles, plus 1 cycle of commit per update.

Decomposition:
- Shared package drbg_pkg: opcode constants OP_INST/OP_RESEED/OP_GEN, state encoding localparams, SEEDLEN=256, BLKLEN=128.
- One sub-module, drbg_state_reg: holds K, V, tmp0 and rcnt with load/increment/commit controls. The FSM lives in drbg_aes_seq.

Test Plan:
The bench uses a stub engine: text_out = text_in ^ key, with done returned 3 cycles after ld.
- Instantiate, seed=0 -> two aes_ld pulses with text_in 1 then 2; final K=1, V=2, rcnt=1, no out_valid.
- After the test above, generate nblk=1 with out_ready=1 -> out_data=128'h2; then update leaves K=5, V=4, rcnt=2.
- Generate with inst=0, then op=3, then nblk=0 -> err pulse each time, cmd_ready stays high, no aes_ld.
- Generate nblk=3 with out_ready held low 10 cycles per block -> out_data stable, no aes_ld until the handshake, exactly 3 blocks then 2 update loads.
- Force V=all-ones, then generate -> aes_text_in=0 (wrap). With RESEED_LIMIT=2, the third generate raises reseed_req and errs; a reseed clears it (rcnt=1).
- Assert rst while in G_W, and fire aes_done 1 cycle after the rst release -> state IDLE, K=V=0, inst=0, no out_valid.

Source files
------------

// File: rtl/drbg_pkg.sv
// Shared constants for the CTR-DRBG sequencer: opcodes, block/seed sizes and
// the sequencer state encoding.
package drbg_pkg;
    localparam int SEEDLEN = 256;
    localparam int BLKLEN  = 128;

    localparam logic [1:0] OP_INST   = 2'd0;
    localparam logic [1:0] OP_RESEED = 2'd1;
    localparam logic [1:0] OP_GEN    = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_U_LD0,
        ST_U_W0,
        ST_U_LD1,
        ST_U_W1,
        ST_U_COMMIT,
        ST_G_LD,
        ST_G_W,
        ST_G_OUT
    } state_t;
endpackage

// File: rtl/drbg_aes_seq_if.sv
// Bundle of the command, random-output and AES-engine handshakes around the
// DRBG sequencer. The sequencer itself uses the slave view.
interface drbg_aes_seq_if;
    import drbg_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [SEEDLEN-1:0] cmd_seed;
    logic [7:0]         cmd_nblk;
    logic               err;
    logic               busy;
    logic               reseed_req;
    logic               out_valid;
    logic               out_ready;
    logic [BLKLEN-1:0]  out_data;
    logic               aes_ld;
    logic [BLKLEN-1:0]  aes_key;
    logic [BLKLEN-1:0]  aes_text_in;
    logic               aes_done;
    logic [BLKLEN-1:0]  aes_text_out;

    modport master (
        output cmd_valid, cmd_op, cmd_seed, cmd_nblk, out_ready, aes_done, aes_text_out,
        input  cmd_ready, err, busy, reseed_req, out_valid, out_data, aes_ld, aes_key, aes_text_in
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_seed, cmd_nblk, out_ready, aes_done, aes_text_out,
        output cmd_ready, err, busy, reseed_req, out_valid, out_data, aes_ld, aes_key, aes_text_in
    );
endinterface

// File: rtl/drbg_state_reg.sv
// DRBG working state: Key, V, the two Update cipher results and the reseed
// counter, with clear / increment / commit controls from the sequencer.
module drbg_state_reg
    import drbg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clr,
    input  logic               v_inc,
    input  logic               tmp0_ld,
    input  logic               tmp1_ld,
    input  logic               commit,
    input  logic               rcnt_set1,
    input  logic               rcnt_inc,
    input  logic [BLKLEN-1:0]  text_out,
    input  logic [SEEDLEN-1:0] pd,
    output logic [BLKLEN-1:0]  k,
    output logic [BLKLEN-1:0]  v,
    output logic [CNT_W-1:0]   rcnt
);
    logic [BLKLEN-1:0] k_reg;
    logic [BLKLEN-1:0] v_reg;
    logic [BLKLEN-1:0] tmp0_reg;
    logic [BLKLEN-1:0] tmp1_reg;
    logic [CNT_W-1:0]  rcnt_reg;
    logic [BLKLEN-1:0] k_next;
    logic [BLKLEN-1:0] v_next;

    // Update commit: upper half of provided data folds into Key, lower into V.
    genvar gi;
    generate
        for (gi = 0; gi < BLKLEN / 32; gi++) begin : g_commit
            assign k_next[gi*32 +: 32] = tmp0_reg[gi*32 +: 32] ^ pd[BLKLEN + gi*32 +: 32];
            assign v_next[gi*32 +: 32] = tmp1_reg[gi*32 +: 32] ^ pd[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            k_reg    <= '0;
            v_reg    <= '0;
            tmp0_reg <= '0;
            tmp1_reg <= '0;
            rcnt_reg <= '0;
        end else begin
            if (clr) begin
                k_reg <= '0;
                v_reg <= '0;
            end else if (commit) begin
                k_reg <= k_next;
                v_reg <= v_next;
            end else if (v_inc) begin
                v_reg <= v_reg + BLKLEN'(1);
            end
            if (tmp0_ld) tmp0_reg <= text_out;
            if (tmp1_ld) tmp1_reg <= text_out;
            if (rcnt_set1) begin
                rcnt_reg <= CNT_W'(1);
            end else if (rcnt_inc && (rcnt_reg != '1)) begin
                rcnt_reg <= rcnt_reg + CNT_W'(1);
            end
        end
    end

    assign k    = k_reg;
    assign v    = v_reg;
    assign rcnt = rcnt_reg;
endmodule

// File: rtl/drbg_aes_seq.sv
// CTR-DRBG sequencer: accepts instantiate/reseed/generate commands, drives one
// AES-128 engine for Update and Generate, and streams random blocks out.
module drbg_aes_seq
    import drbg_pkg::*;
#(
    parameter int               CNT_W        = 32,
    parameter logic [CNT_W-1:0] RESEED_LIMIT = CNT_W'(32'h0001_0000)
) (
    input  logic          clk,
    input  logic          rst,
    drbg_aes_seq_if.slave bus
);
    state_t             state_reg;
    state_t             state_next;
    logic [SEEDLEN-1:0] seed_reg;
    logic [7:0]         nblk_reg;
    logic               gen_reg;
    logic               inst_reg;
    logic [BLKLEN-1:0]  out_data_reg;
    logic               out_valid_reg;
    logic               err_reg;
    logic               aes_ld_reg;

    logic               cmd_bad;
    logic               accept;
    logic               reject;
    logic               clr;
    logic               v_inc;
    logic               tmp0_ld;
    logic               tmp1_ld;
    logic               commit;
    logic               rcnt_set1;
    logic               rcnt_inc;
    logic               out_load;
    logic               out_take;
    logic [SEEDLEN-1:0] pd;
    logic [BLKLEN-1:0]  k;
    logic [BLKLEN-1:0]  v;
    logic [CNT_W-1:0]   rcnt;

    // The post-generate Update runs with all-zero provided data.
    assign pd = gen_reg ? '0 : seed_reg;

    drbg_state_reg #(.CNT_W(CNT_W)) u_state (
        .clk       (clk),
        .srst      (rst),
        .clr       (clr),
        .v_inc     (v_inc),
        .tmp0_ld   (tmp0_ld),
        .tmp1_ld   (tmp1_ld),
        .commit    (commit),
        .rcnt_set1 (rcnt_set1),
        .rcnt_inc  (rcnt_inc),
        .text_out  (bus.aes_text_out),
        .pd        (pd),
        .k         (k),
        .v         (v),
        .rcnt      (rcnt)
    );

    assign cmd_bad = (bus.cmd_op == 2'd3)
                  || ((bus.cmd_op != OP_INST) && !inst_reg)
                  || ((bus.cmd_op == OP_GEN) && ((bus.cmd_nblk == 8'd0) || (rcnt > RESEED_LIMIT)));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        clr        = 1'b0;
        v_inc      = 1'b0;
        tmp0_ld    = 1'b0;
        tmp1_ld    = 1'b0;
        commit     = 1'b0;
        rcnt_set1  = 1'b0;
        rcnt_inc   = 1'b0;
        out_load   = 1'b0;
        out_take   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        clr        = (bus.cmd_op == OP_INST);
                        state_next = (bus.cmd_op == OP_GEN) ? ST_G_LD : ST_U_LD0;
                    end
                end
            end
            ST_U_LD0: begin
                v_inc      = 1'b1;
                state_next = ST_U_W0;
            end
            ST_U_W0: begin
                if (bus.aes_done) begin
                    tmp0_ld    = 1'b1;
                    state_next = ST_U_LD1;
                end
            end
            ST_U_LD1: begin
                v_inc      = 1'b1;
                state_next = ST_U_W1;
            end
            ST_U_W1: begin
                if (bus.aes_done) begin
                    tmp1_ld    = 1'b1;
                    state_next = ST_U_COMMIT;
                end
            end
            ST_U_COMMIT: begin
                commit     = 1'b1;
                rcnt_inc   = gen_reg;
                rcnt_set1  = !gen_reg;
                state_next = ST_IDLE;
            end
            ST_G_LD: begin
                v_inc      = 1'b1;
                state_next = ST_G_W;
            end
            ST_G_W: begin
                if (bus.aes_done) begin
                    out_load   = 1'b1;
                    state_next = ST_G_OUT;
                end
            end
            ST_G_OUT: begin
                if (bus.out_ready) begin
                    out_take   = 1'b1;
                    state_next = (nblk_reg == 8'd1) ? ST_U_LD0 : ST_G_LD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // V is already incremented when the start pulse goes out one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_reg      <= '0;
            nblk_reg      <= '0;
            gen_reg       <= 1'b0;
            inst_reg      <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            aes_ld_reg    <= 1'b0;
        end else begin
            err_reg    <= reject;
            aes_ld_reg <= (state_reg == ST_U_LD0) || (state_reg == ST_U_LD1) || (state_reg == ST_G_LD);
            if (accept) begin
                seed_reg <= bus.cmd_seed;
                nblk_reg <= bus.cmd_nblk;
                gen_reg  <= (bus.cmd_op == OP_GEN);
            end
            if (out_load) begin
                out_data_reg  <= bus.aes_text_out;
                out_valid_reg <= 1'b1;
            end else if (out_take) begin
                out_valid_reg <= 1'b0;
                nblk_reg      <= nblk_reg - 8'd1;
            end
            if (commit && !gen_reg) inst_reg <= 1'b1;
        end
    end

    assign bus.cmd_ready   = (state_reg == ST_IDLE);
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.err         = err_reg;
    assign bus.reseed_req  = (rcnt > RESEED_LIMIT);
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.aes_ld      = aes_ld_reg;
    assign bus.aes_key     = k;
    assign bus.aes_text_in = v;
endmodule

// File: tb/tb_drbg_aes_seq.sv
// Scoreboard bench for drbg_aes_seq with an XOR stub cipher (done 3 cycles
// after ld); expected AES inputs and output blocks come from a bench model.
module tb_drbg_aes_seq;
    import drbg_pkg::*;

    localparam int unsigned LIMIT = 2;

    logic clk;
    logic rst;
    drbg_aes_seq_if bus ();

    drbg_aes_seq #(.CNT_W(32), .RESEED_LIMIT(32'd2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ld_count = 0;
    bit stub_en = 1'b1;

    logic [127:0] exp_ld[$];
    logic [127:0] exp_out[$];

    logic [127:0] mk;
    logic [127:0] mv;
    int unsigned  mrcnt;
    bit           minst;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_update(input logic [255:0] pd);
        logic [127:0] t0;
        logic [127:0] t1;
        mv = mv + 128'd1;
        exp_ld.push_back(mv);
        t0 = mv ^ mk;
        mv = mv + 128'd1;
        exp_ld.push_back(mv);
        t1 = mv ^ mk;
        mk = t0 ^ pd[255:128];
        mv = t1 ^ pd[127:0];
    endtask

    task automatic model_gen(input int n);
        for (int b = 0; b < n; b++) begin
            mv = mv + 128'd1;
            exp_ld.push_back(mv);
            exp_out.push_back(mv ^ mk);
        end
        model_update('0);
        if (mrcnt != 32'hFFFF_FFFF) mrcnt++;
    endtask

    // Stub engine plus AES-start monitor.
    initial begin
        int           cnt;
        logic [127:0] res;
        cnt = 0;
        res = '0;
        forever begin
            @(posedge clk); #1;
            if (stub_en) begin
                bus.aes_done = 1'b0;
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.aes_text_out = res;
                        bus.aes_done     = 1'b1;
                    end
                end
                if (bus.aes_ld) begin
                    ld_count++;
                    if (exp_ld.size() == 0) chk("ld_extra", 1, 0);
                    else chk("ld_text_in", bus.aes_text_in, exp_ld.pop_front());
                    res = bus.aes_text_in ^ bus.aes_key;
                    cnt = 3;
                end
            end
        end
    end

    // Output scoreboard and backpressure stability monitor.
    initial begin
        bit           hold_prev;
        logic [127:0] data_prev;
        hold_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("out_hold_valid", bus.out_valid, 1);
                    chk("out_hold_data", bus.out_data, data_prev);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_out.size() == 0) chk("out_extra", 1, 0);
                    else chk("out_data", bus.out_data, exp_out.pop_front());
                end
                hold_prev = bus.out_valid && !bus.out_ready;
                data_prev = bus.out_data;
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [255:0] seed, input logic [7:0] nblk);
        bit rej;
        int ld0;
        rej = (op == 2'd3) || ((op != OP_INST) && !minst)
           || ((op == OP_GEN) && ((nblk == 8'd0) || (mrcnt > LIMIT)));
        if (!rej) begin
            case (op)
                OP_INST: begin
                    mk = '0;
                    mv = '0;
                    model_update(seed);
                    mrcnt = 1;
                    minst = 1'b1;
                end
                OP_RESEED: begin
                    model_update(seed);
                    mrcnt = 1;
                end
                default: model_gen(int'(nblk));
            endcase
        end
        ld0 = ld_count;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_seed  = seed;
        bus.cmd_nblk  = nblk;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("err", bus.err, rej);
        if (rej) begin
            @(posedge clk); #1;
            chk("err_clear", bus.err, 0);
            chk("cmd_ready_rej", bus.cmd_ready, 1);
            @(posedge clk); #1;
            chk("no_ld_rej", ld_count, ld0);
        end else begin
            chk("busy", bus.busy, 1);
            for (int i = 0; i < 3000; i++) begin
                if (!bus.busy) break;
                @(posedge clk); #1;
            end
            chk("idle_timeout", bus.busy, 0);
            chk("key", bus.aes_key, mk);
            chk("v", bus.aes_text_in, mv);
            chk("rcnt", dut.u_state.rcnt_reg, mrcnt);
            chk("inst", dut.inst_reg, minst);
            chk("reseed_req", bus.reseed_req, mrcnt > LIMIT);
            chk("ld_pending", exp_ld.size(), 0);
            chk("out_pending", exp_out.size(), 0);
        end
    endtask

    task automatic slow_sink(input int nblk);
        int w;
        int ld0;
        for (int b = 0; b < nblk; b++) begin
            w = 0;
            while (!bus.out_valid && w < 300) begin
                @(posedge clk); #1;
                w++;
            end
            chk("sink_valid_timeout", bus.out_valid, 1);
            ld0 = ld_count;
            repeat (10) begin @(posedge clk); #1; end
            chk("no_ld_stalled", ld_count, ld0);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] seed;
        logic [127:0] t1;
        int           ld_start;

        rst = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 2'd0;
        bus.cmd_seed     = '0;
        bus.cmd_nblk     = 8'd0;
        bus.out_ready    = 1'b1;
        bus.aes_done     = 1'b0;
        bus.aes_text_out = '0;
        mk = '0; mv = '0; mrcnt = 0; minst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_aes_ld", bus.aes_ld, 0);
        chk("rst_key", bus.aes_key, 0);
        chk("rst_v", bus.aes_text_in, 0);
        chk("rst_rcnt", dut.u_state.rcnt_reg, 0);

        do_cmd(OP_GEN, '0, 8'd1);        // not instantiated
        do_cmd(2'd3, '0, 8'd1);          // reserved op
        do_cmd(OP_INST, '0, 8'd0);       // K=1 V=2
        chk("inst_key_1", bus.aes_key, 128'h1);
        chk("inst_v_2", bus.aes_text_in, 128'h2);
        do_cmd(OP_GEN, '0, 8'd1);        // out 2, then K=5 V=4
        chk("gen_key_5", bus.aes_key, 128'h5);
        chk("gen_v_4", bus.aes_text_in, 128'h4);
        do_cmd(OP_GEN, '0, 8'd0);        // nblk=0
        do_cmd(OP_GEN, '0, 8'd1);        // rcnt 2 -> 3
        chk("reseed_req_high", bus.reseed_req, 1);
        do_cmd(OP_GEN, '0, 8'd1);        // over the limit
        do_cmd(OP_RESEED, rand256(), 8'd0);
        chk("reseed_req_clr", bus.reseed_req, 0);

        ld_start = ld_count;
        bus.out_ready = 1'b0;
        fork
            do_cmd(OP_GEN, '0, 8'd3);
            slow_sink(3);
        join
        bus.out_ready = 1'b1;
        chk("slow_ld_count", ld_count - ld_start, 5);

        // Choose reseed data so the committed V is all-ones.
        t1   = (mv + 128'd2) ^ mk;
        seed = rand256();
        seed[127:0] = ~t1;
        do_cmd(OP_RESEED, seed, 8'd0);
        chk("v_all_ones", bus.aes_text_in, {128{1'b1}});
        do_cmd(OP_GEN, '0, 8'd1);        // first text_in must wrap to 0

        do_cmd(OP_RESEED, rand256(), 8'd0);
        do_cmd(OP_GEN, '0, 8'($urandom_range(2, 4)));

        // Reset while waiting on the engine; a late done must be ignored.
        stub_en = 1'b0;
        @(posedge clk); #1;
        bus.aes_done  = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_GEN;
        bus.cmd_nblk  = 8'd1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("gw_aes_ld", bus.aes_ld, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.aes_done     = 1'b1;
        bus.aes_text_out = rand256()[127:0];
        @(posedge clk); #1;
        bus.aes_done = 1'b0;
        repeat (3) begin
            chk("post_rst_out_valid", bus.out_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
            chk("post_rst_aes_ld", bus.aes_ld, 0);
            @(posedge clk); #1;
        end
        chk("post_rst_key", bus.aes_key, 0);
        chk("post_rst_v", bus.aes_text_in, 0);
        chk("post_rst_inst", dut.inst_reg, 0);
        chk("post_rst_rcnt", dut.u_state.rcnt_reg, 0);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
